// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared types, constants and ratio check for the clock divider controller
package clock_div_pkg;

    // Controller operating state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest ratio that still yields a high and a low phase
    localparam int unsigned MIN_DIV = 2;

    // A ratio is usable when it lies in MIN_DIV..max_div inclusive
    function automatic bit div_legal(input int unsigned val, input int unsigned max_div);
        return (val >= MIN_DIV) && (val <= max_div);
    endfunction

endpackage

// File: rtl/clock_div_phase.sv
// rtl/clock_div_phase.sv - phase counter producing the period strobe and divided clock
module clock_div_phase
    import clock_div_pkg::*;
#(
    parameter int DIV_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_active,   // controller currently in RUN
    input  logic             i_go,       // controller will be in RUN next cycle
    input  logic [DIV_W-1:0] i_div,      // ratio of the period now running
    input  logic [DIV_W-1:0] i_div_nxt,  // ratio in effect next cycle
    output logic             o_wrap,     // last cycle of the running period
    output logic             o_clk_en,
    output logic             o_clkout
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clk_en;
    logic             r_clkout;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_half;
    logic             w_wrap;

    // Next phase: restart at 0 when starting from IDLE or at the end of a period
    always_comb begin
        w_wrap    = i_active && (r_cnt == (i_div - ONE));
        w_cnt_nxt = (!i_active || w_wrap) ? '0 : (r_cnt + ONE);
        w_half    = i_div_nxt >> 1;
    end

    // Outputs are registered from the next phase so they line up with the counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_clkout <= 1'b0;
        end else begin
            r_cnt    <= i_go ? w_cnt_nxt : '0;
            r_clk_en <= i_go && (w_cnt_nxt == '0);
            r_clkout <= i_go && (w_cnt_nxt < w_half);
        end
    end

    assign o_wrap   = w_wrap;
    assign o_clk_en = r_clk_en;
    assign o_clkout = r_clkout;

endmodule

// File: rtl/clock_div_ctrl.sv
// rtl/clock_div_ctrl.sv - programmable clock divider controller; CLOCK_DIV_CTRL_PERIOD_CNT_EN adds o_period_cnt
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter  int MAX_DIV     = 16,
    parameter  int DEFAULT_DIV = 3,
    localparam int DIV_W       = $clog2(MAX_DIV + 1)
) (
    input  logic             i_clkin,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_div_req,
    input  logic [DIV_W-1:0] i_div_val,
    output logic             o_div_ack,
    output logic             o_div_err,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_cur_div,
    output logic             o_clk_en,
    output logic             o_clkout
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]      o_period_cnt
`endif
);

    state_t           r_state;
    logic             r_busy;
    logic             r_ack;
    logic             r_err;
    logic [DIV_W-1:0] r_cur;
    logic [DIV_W-1:0] r_pend;

    logic             w_active;
    logic             w_wrap;
    logic             w_accept;
    logic             w_legal;
    logic             w_apply;
    logic             w_go;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_clk_en;
    logic             w_clkout;

    // Handshake and boundary decisions; a pending ratio lands only when no period is cut short
    always_comb begin
        w_active  = (r_state == RUN);
        w_accept  = i_div_req && !r_busy && !r_ack;
        w_legal   = div_legal(32'(i_div_val), MAX_DIV);
        w_apply   = r_busy && (!w_active || w_wrap);
        w_go      = w_active ? !(w_wrap && !i_enable) : i_enable;
        w_div_nxt = r_cur;
        if (w_apply) begin
            w_div_nxt = r_pend;
        end else if (w_accept && w_legal && !w_active) begin
            w_div_nxt = i_div_val;
        end
    end

    // FSM, request handshake and current ratio
    always_ff @(posedge i_clkin) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_cur   <= DIV_W'(DEFAULT_DIV);
            r_pend  <= DIV_W'(DEFAULT_DIV);
        end else begin
            r_state <= w_go ? RUN : IDLE;
            r_cur   <= w_div_nxt;
            r_ack   <= w_apply || (w_accept && (!w_legal || !w_active));
            r_err   <= w_accept && !w_legal;
            if (w_apply) begin
                r_busy <= 1'b0;
            end else if (w_accept && w_legal && w_active) begin
                r_busy <= 1'b1;
            end
            if (w_accept) begin
                r_pend <= i_div_val;
            end
        end
    end

    clock_div_phase #(
        .DIV_W(DIV_W)
    ) u_phase (
        .i_clk     (i_clkin),
        .i_reset   (i_reset),
        .i_active  (w_active),
        .i_go      (w_go),
        .i_div     (r_cur),
        .i_div_nxt (w_div_nxt),
        .o_wrap    (w_wrap),
        .o_clk_en  (w_clk_en),
        .o_clkout  (w_clkout)
    );

`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    // Count completed period starts; naturally holds in IDLE since no strobe occurs
    always_ff @(posedge i_clkin) begin
        if (i_reset) begin
            r_period_cnt <= 16'd0;
        end else if (w_clk_en) begin
            r_period_cnt <= r_period_cnt + 16'd1;
        end
    end

    assign o_period_cnt = r_period_cnt;
`endif

    assign o_div_ack = r_ack;
    assign o_div_err = r_err;
    assign o_busy    = r_busy;
    assign o_cur_div = r_cur;
    assign o_clk_en  = w_clk_en;
    assign o_clkout  = w_clkout;

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Runtime-programmable integer clock divider controller.
- Generates a registered divided clock (clkout) and a one-cycle period-start strobe (clk_en) from clkin.
- Sequences divide-ratio changes so they take effect only at period boundaries: no runt pulses.
- Sits between a config/CSR requester and downstream logic that needs slower clocks or enables; replaces hard-wired fixed-ratio dividers.

Parameters:
- MAX_DIV, 16: largest accepted divide ratio (>= 2).
- DEFAULT_DIV, 3: ratio loaded at reset (2..MAX_DIV).
- DIV_W, $clog2(MAX_DIV+1): width of ratio fields (localparam, derived).

Ports:
- clkin  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; low = stop at next period boundary.
- div_req  in  1  ratio-change request; held until div_ack.
- div_val  in  DIV_W  requested ratio; sampled when the request is accepted.
- div_ack  out  1  one-cycle pulse: request completed (applied or rejected).
- div_err  out  1  one-cycle pulse, coincident with div_ack: div_val illegal.
- busy  out  1  request accepted, not yet acked.
- cur_div  out  DIV_W  ratio currently in effect.
- clk_en  out  1  one-cycle strobe on first cycle of each output period.
- clkout  out  1  divided clock.

Behaviour:
- Single clock: clkin. Reset is synchronous and active-high (reset). All outputs registered.
- Reset values: clkout=0, clk_en=0, div_ack=0, div_err=0, busy=0, cur_div=DEFAULT_DIV. State=IDLE, phase counter cnt=0.
- Reset mid-operation: next cycle equals reset state. Any pending request is dropped with no ack.
- States:
  - IDLE: clkout=0; when enable=1 -> RUN, cnt=0.
  - RUN: cnt steps 0..N-1 and wraps, N=cur_div. At wrap (cnt==N-1) with enable=0 -> IDLE.
- Output pattern in RUN:
  - clk_en=1 iff cnt==0.
  - clkout=1 iff cnt < N/2 (integer floor).
  - N=3 -> clkout 1,0,0. N=4 -> 1,1,0,0. N=5 -> 1,1,0,0,0.
- Latency: enable sampled high in IDLE -> first clk_en/clkout high on the next cycle.
- Enable low mid-period: current period completes in full, then IDLE. Re-assert during the final cycle -> stay in RUN, no gap.
- Request acceptance:
  - Accepted on any cycle with div_req=1, busy=0, div_ack=0. div_val latched into pend, busy=1.
  - The requester drops div_req the cycle after div_ack. div_req still high then counts as a new request.
- Legal ratios: 2..MAX_DIV. Illegal (0, 1, >MAX_DIV) -> next cycle div_ack=1, div_err=1, busy=0, cur_div unchanged.
- Legal ratio in IDLE: next cycle cur_div=pend, div_ack=1, busy=0.
- Legal ratio in RUN:
  - Applied at wrap. The cycle after cnt==N-1 starts a new period with the new N, clk_en=1, div_ack=1, busy=0.
  - Accepted during the wrap cycle itself -> applied at the following wrap.
- Simultaneous enable rise and legal request in IDLE: ratio applied first. div_ack coincides with the first clk_en, and the first period uses the new ratio.
- Request pending while enable drops: applied at the same boundary that enters IDLE. Ack is still issued.

Optional Feature:
- Macro CLOCK_DIV_CTRL_PERIOD_CNT_EN.
- Defined: extra output port period_cnt, out, 16 bits.
  - Increments on each clk_en; wraps 0xFFFF -> 0.
  - Cleared by reset; holds in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package clock_div_pkg:
  - state enum {IDLE, RUN}.
  - MIN_DIV=2 constant.
  - Function div_legal(val, max) returning bit.
- Sub-module clock_div_phase: cnt, clk_en and clkout generation, with load/ratio inputs and a wrap output.
- clock_div_ctrl owns the FSM, the request handshake and cur_div.

Test Plan:
1. Reset, enable=1, no requests -> clk_en every 3rd cycle from cycle 1 after enable; clkout 1,0,0 repeating; cur_div=3.
2. RUN N=3, div_req with div_val=4 at cnt=1 -> busy 1; N=3 period completes; next cycle clk_en=1 and div_ack=1; then clkout 1,1,0,0; cur_div=4.
3. div_val=1, then div_val=17 (MAX_DIV=16) -> each gives div_ack=div_err=1 the next cycle; cur_div and waveform unchanged.
4. N=5, enable dropped at cnt=1 -> remaining 3 cycles of the period complete, then clkout=0 and no clk_en; re-enable -> clk_en on the next cycle.
5. IDLE, enable and div_req (div_val=2) rise together -> next cycle div_ack=1, clk_en=1, clkout=1; then clkout toggles every cycle.
6. Reset asserted mid-period with a request pending -> next cycle all outputs at reset values, no div_ack; with PERIOD_CNT_EN, period_cnt=0, then counts to 0xFFFF and wraps to 0.
